// File: rtl/seg_scan_mux.sv
// seg_scan_mux: registered time-multiplexed scanner for a common-pin multi-digit 7-segment display.
// Build option SEG_SCAN_SKIP_EN: disabled digits are skipped instead of occupying blank slots.
module seg_scan_mux #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 4,
    parameter int BLANK_CYCLES = 1
) (
    input  logic                    clk_div,
    input  logic                    rst_n,
    input  logic [7*NUM_DIGITS-1:0] seg_data,
    input  logic [NUM_DIGITS-1:0]   dig_en,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   dig,
    output logic                    frame_tick
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

    logic [CNT_W-1:0]      div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] dig_q, dig_d;
    logic                  frame_tick_q, frame_tick_d;
    logic [6:0]            seg_arr [NUM_DIGITS];
    logic                  lit;
    logic                  slot_end;

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_seg_split
        assign seg_arr[gi] = seg_data[7*gi +: 7];
    end

`ifdef SEG_SCAN_SKIP_EN
    // cand[gi] is the digit gi+1 positions after idx, circularly; idx itself comes last.
    logic [IDX_W-1:0] cand [NUM_DIGITS];
    logic [IDX_W-1:0] skip_idx;
    logic             skip_found;

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_cand
        logic [IDX_W:0] sum;
        assign sum      = {1'b0, idx_q} + (IDX_W+1)'(gi + 1);
        assign cand[gi] = (sum > {1'b0, IDX_LAST}) ? IDX_W'(sum - (IDX_W+1)'(NUM_DIGITS))
                                                   : sum[IDX_W-1:0];
    end

    always_comb begin
        skip_idx   = '0;
        skip_found = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            if (dig_en[cand[k]]) begin
                skip_idx   = cand[k];
                skip_found = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        slot_end     = (div_cnt_q == CNT_LAST);
        lit          = dig_en[idx_q] && (div_cnt_q >= BLANK_END);
        div_cnt_d    = slot_end ? '0 : div_cnt_q + CNT_W'(1);
        idx_d        = idx_q;
        frame_tick_d = 1'b0;
        dig_d        = '1;
        seg_d        = 7'h7F;
        if (lit) begin
            dig_d[idx_q] = 1'b0;
            seg_d        = ~seg_arr[idx_q];
        end
        if (slot_end) begin
`ifdef SEG_SCAN_SKIP_EN
            // With nothing enabled the scanner parks on digit 0 and never signals a frame.
            idx_d        = skip_found ? skip_idx : '0;
            frame_tick_d = skip_found && (skip_idx <= idx_q);
`else
            idx_d        = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            frame_tick_d = (idx_q == IDX_LAST);
`endif
        end
    end

    always_ff @(posedge clk_div) begin
        if (!rst_n) begin
            div_cnt_q    <= '0;
            idx_q        <= '0;
            dig_q        <= '1;
            seg_q        <= 7'h7F;
            frame_tick_q <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            idx_q        <= idx_d;
            dig_q        <= dig_d;
            seg_q        <= seg_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign seg        = seg_q;
    assign dig        = dig_q;
    assign frame_tick = frame_tick_q;
endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux: driver pushes expected pin values per edge, monitor pops and compares.
// The reference model follows SEG_SCAN_SKIP_EN the same way the design build does.
module tb_seg_scan_mux;
    localparam int N  = 4;
    localparam int SD = 4;
    localparam int BL = 1;

    logic        clk_div  = 1'b0;
    logic        rst_n    = 1'b0;
    logic [27:0] seg_data = '0;
    logic [3:0]  dig_en   = '0;
    logic [6:0]  seg;
    logic [3:0]  dig;
    logic        frame_tick;

    seg_scan_mux #(.NUM_DIGITS(N), .SCAN_DIV(SD), .BLANK_CYCLES(BL)) dut (
        .clk_div    (clk_div),
        .rst_n      (rst_n),
        .seg_data   (seg_data),
        .dig_en     (dig_en),
        .seg        (seg),
        .dig        (dig),
        .frame_tick (frame_tick)
    );

    always #5 clk_div = ~clk_div;

    typedef struct {
        logic [3:0] dig;
        logic [6:0] seg;
        logic       tick;
        int         step;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   step_no     = 0;
    int   m_t         = 0;  // edges since the last reset
    int   m_idx       = 0;  // current digit in skip mode

    // Drive one edge worth of inputs and record what the pins must show after that edge.
    task automatic apply(input logic r, input logic [3:0] en, input logic [27:0] data);
        exp_t e;
        int   cur;
        int   k;
`ifdef SEG_SCAN_SKIP_EN
        int   list[$];
        int   nxt;
`endif
        @(negedge clk_div);
        rst_n    = r;
        dig_en   = en;
        seg_data = data;
        e.dig  = 4'hF;
        e.seg  = 7'h7F;
        e.tick = 1'b0;
        e.step = step_no;
        step_no++;
        if (!r) begin
            m_t   = 0;
            m_idx = 0;
        end else begin
            k = m_t % SD;
`ifdef SEG_SCAN_SKIP_EN
            cur = m_idx;
`else
            cur = (m_t / SD) % N;
`endif
            if (en[cur] && k >= BL) begin
                e.dig = ~(4'b0001 << cur);
                e.seg = ~data[7*cur +: 7];
            end
            if (k == SD - 1) begin
`ifdef SEG_SCAN_SKIP_EN
                list = {};
                for (int d = 0; d < N; d++) if (en[d]) list.push_back(d);
                if (list.size() == 0) begin
                    m_idx = 0;
                end else begin
                    nxt = -1;
                    foreach (list[j]) if (nxt < 0 && list[j] > cur) nxt = list[j];
                    if (nxt < 0) begin
                        nxt    = list[0];
                        e.tick = 1'b1;
                    end
                    m_idx = nxt;
                end
`else
                e.tick = (cur == N - 1);
`endif
            end
            m_t++;
        end
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk_div);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (dig !== e.dig || seg !== e.seg || frame_tick !== e.tick) begin
                    miscompares++;
                    $display("FAIL step%0d pins: got dig=%b seg=%h tick=%b, want dig=%b seg=%h tick=%b",
                             e.step, dig, seg, frame_tick, e.dig, e.seg, e.tick);
                end else begin
                    $display("step%0d ok dig=%b seg=%h tick=%b", e.step, dig, seg, frame_tick);
                end
            end
        end
    end

    localparam logic [27:0] DEMO = {7'h07, 7'h4F, 7'h5B, 7'h06};

    initial begin : driver
        logic [3:0]  en;
        logic [27:0] data;
        repeat (3) apply(1'b0, 4'hF, DEMO);
        repeat (40) apply(1'b1, 4'hF, DEMO);
        repeat (40) apply(1'b1, 4'b1011, DEMO);
        repeat (64) apply(1'b1, 4'b0000, DEMO);
        repeat (20) apply(1'b1, 4'b0100, DEMO);
        // Restart full scan, then reset while digit 2 is lit (slot cycles 8..11 from restart).
        apply(1'b0, 4'hF, DEMO);
        repeat (10) apply(1'b1, 4'hF, DEMO);
        apply(1'b0, 4'hF, DEMO);
        repeat (20) apply(1'b1, 4'hF, DEMO);
        en   = 4'hF;
        data = DEMO;
        for (int i = 0; i < 1200; i++) begin
            if ($urandom_range(0, 39) == 0) en = 4'($urandom);
            if ($urandom_range(0, 3) == 0) data = 28'($urandom);
            apply(($urandom_range(0, 199) != 0), en, data);
        end
        @(posedge clk_div);
        @(posedge clk_div);
        #2;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
